// File: rtl/key_pkg.sv
// Shared types and constants for the c432 key loader.
package key_pkg;

    localparam int unsigned KEY_WIDTH_DEF = 10;

    // Correct unlock key for the locked c432 netlist (bits 0 and 1 set).
    localparam logic [9:0] C432_KEY = 10'b0000000011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/key_shift_reg.sv
// Serial-to-parallel key capture: LSB-first shift register, beat counter and running parity.
module key_shift_reg
    import key_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEF,
    parameter int unsigned CNT_W     = $clog2(KEY_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 sdata,
    output logic [KEY_WIDTH-1:0] data,
    output logic [CNT_W-1:0]     count,
    output logic                 parity
);

    // Bit lands at the position given by the count of bits already captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            count  <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            data   <= '0;
            count  <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
                if (count == CNT_W'(i)) begin
                    data[i] <= sdata;
                end
            end
            count  <= count + CNT_W'(1);
            parity <= parity ^ sdata;
        end
    end

endmodule

// File: rtl/key_loader.sv
// Loads the c432 unlock key over a serial valid/ready stream, checks even parity and
// commits it to the key gates; key_out stays zero until a good key is committed.
module key_loader
    import key_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEF,
    parameter int unsigned TIMEOUT   = 255,
    parameter bit          LOCK_ONCE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 key_sdata,
    input  logic                 key_svalid,
    output logic                 key_sready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 key_err
);

    localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    state_t               state, state_nxt;
    logic [TO_W-1:0]      tcnt, tcnt_nxt;
    logic [KEY_WIDTH-1:0] key_nxt;
    logic                 valid_nxt;
    logic                 err_nxt;
    logic                 clr_c;
    logic                 bit_en_c;
    logic                 full_c;

    logic [KEY_WIDTH-1:0] sr_data;
    logic [CNT_W-1:0]     sr_count;
    logic                 sr_parity;

    key_shift_reg #(
        .KEY_WIDTH (KEY_WIDTH),
        .CNT_W     (CNT_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_c),
        .shift_en (bit_en_c),
        .sdata    (key_sdata),
        .data     (sr_data),
        .count    (sr_count),
        .parity   (sr_parity)
    );

    assign full_c     = (sr_count == CNT_W'(KEY_WIDTH));
    assign key_sready = (state == SHIFT);
    assign busy       = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tcnt      <= tcnt_nxt;
            key_out   <= key_nxt;
            key_valid <= valid_nxt;
            key_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        key_nxt   = key_out;
        valid_nxt = key_valid;
        err_nxt   = key_err;
        clr_c     = 1'b0;
        bit_en_c  = 1'b0;

        case (state)
            IDLE, ERR: begin
                if (load_start) begin
                    state_nxt = SHIFT;
                    tcnt_nxt  = '0;
                    err_nxt   = 1'b0;
                    clr_c     = 1'b1;
                end
            end
            DONE: begin
                if (load_start && !LOCK_ONCE) begin
                    state_nxt = SHIFT;
                    tcnt_nxt  = '0;
                    err_nxt   = 1'b0;
                    key_nxt   = '0;
                    valid_nxt = 1'b0;
                    clr_c     = 1'b1;
                end
            end
            SHIFT: begin
                // A restart discards any bit offered in the same cycle.
                if (load_start) begin
                    tcnt_nxt = '0;
                    clr_c    = 1'b1;
                end else if (key_svalid) begin
                    tcnt_nxt = '0;
                    if (full_c) begin
                        if (sr_parity ^ key_sdata) begin
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                            key_nxt   = '0;
                            valid_nxt = 1'b0;
                        end else begin
                            state_nxt = DONE;
                            key_nxt   = sr_data;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        bit_en_c = 1'b1;
                    end
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    tcnt_nxt  = TO_W'(TIMEOUT);
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                    key_nxt   = '0;
                    valid_nxt = 1'b0;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
